// File: rtl/counter_rf_bridge_pkg.sv
// Shared definitions for the counter register-file bridge: FSM encoding and sizing helpers.
package counter_rf_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    LOAD_WAIT = 2'd2
  } state_e;

  // Cycles held after the load pulse so the counter's registered load path settles.
  localparam int unsigned LOAD_WAIT_CYCLES = 2;

  // Number of bus-wide chunks needed to cover the counter.
  function automatic int unsigned chunk_count(input int unsigned cnt_w, input int unsigned bus_w);
    return (cnt_w + bus_w - 1) / bus_w;
  endfunction

  // Chunk address width, never below one bit.
  function automatic int unsigned addr_width(input int unsigned chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage

// File: rtl/counter_rf_bridge_if.sv
// RF-side access bus between the generated register decode and the counter bridge.
interface counter_rf_bridge_if #(
  parameter int unsigned AW        = 2,
  parameter int unsigned BUS_WIDTH = 16
);

  logic [AW-1:0]        rf_address;
  logic                 rf_read_en;
  logic                 rf_write_en;
  logic [BUS_WIDTH-1:0] rf_write_data;
  logic [BUS_WIDTH-1:0] rf_read_data;
  logic                 rf_access_complete;

  modport master (
    output rf_address, rf_read_en, rf_write_en, rf_write_data,
    input  rf_read_data, rf_access_complete
  );

  modport slave (
    input  rf_address, rf_read_en, rf_write_en, rf_write_data,
    output rf_read_data, rf_access_complete
  );

endinterface

// File: rtl/counter48.sv
// Loadable free-running counter; load value and enable are registered before they take effect.
module counter48 #(
  parameter int unsigned DATASIZE = 48,
  parameter bit          LOADABLE = 1'b1
) (
  input  logic                clk,
  input  logic                res,
  input  logic                increment,
  input  logic [DATASIZE-1:0] load,
  input  logic                load_enable,
  output logic [DATASIZE-1:0] value
);

  logic [DATASIZE-1:0] load_q;
  logic                load_en_q;
  logic                do_load_c;

  assign do_load_c = LOADABLE && load_en_q;

  // Register the load request, then count or load.
  always_ff @(posedge clk) begin
    if (res) begin
      load_q    <= '0;
      load_en_q <= 1'b0;
      value     <= '0;
    end else begin
      load_q    <= load;
      load_en_q <= load_enable;
      if (do_load_c) begin
        value <= load_q;
      end else if (increment) begin
        value <= value + DATASIZE'(1);
      end
    end
  end

endmodule

// File: rtl/counter_rf_bridge.sv
// Serves chunked reads (coherent via a chunk-0 snapshot) and staged loads of a wide counter.
module counter_rf_bridge
  import counter_rf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 48,
  parameter int unsigned BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res,
  counter_rf_bridge_if.slave   rf,
  input  logic [CNT_WIDTH-1:0] cnt_value,
  output logic [CNT_WIDTH-1:0] cnt_load,
  output logic                 cnt_load_enable
);

  localparam int unsigned CHUNKS = chunk_count(CNT_WIDTH, BUS_WIDTH);
  localparam int unsigned AW     = addr_width(CHUNKS);
  localparam int unsigned PW     = CHUNKS * BUS_WIDTH;
  localparam int unsigned WCW    = $clog2(LOAD_WAIT_CYCLES + 1);

  state_e               state;
  logic [CNT_WIDTH-1:0] snapshot;
  logic [CNT_WIDTH-1:0] staging;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                 complete;
  logic                 load_en;
  logic [WCW-1:0]       wait_cnt;

  logic [AW-1:0]        addr_c;
  logic [31:0]          addr_idx_c;
  logic                 addr_ok_c;
  logic                 addr_zero_c;
  logic [PW-1:0]        live_pad_c;
  logic [PW-1:0]        snap_pad_c;
  logic [PW-1:0]        stage_pad_c;
  logic [PW-1:0]        stage_wr_c;
  logic [BUS_WIDTH-1:0] snap_sel_c;

  assign addr_c      = rf.rf_address;
  assign addr_idx_c  = 32'(addr_c);
  assign addr_ok_c   = addr_idx_c < CHUNKS;
  assign addr_zero_c = addr_idx_c == 32'd0;

  // Zero-padded views so a partial top chunk reads as 0.
  assign live_pad_c  = PW'(cnt_value);
  assign snap_pad_c  = PW'(snapshot);
  assign stage_pad_c = PW'(staging);

  // Staging with the addressed chunk replaced by the write data.
  for (genvar g = 0; g < CHUNKS; g++) begin : g_chunk
    assign stage_wr_c[g*BUS_WIDTH +: BUS_WIDTH] =
      (addr_idx_c == 32'(g)) ? rf.rf_write_data : stage_pad_c[g*BUS_WIDTH +: BUS_WIDTH];
  end

  // Addressed snapshot chunk; zero for out-of-range addresses.
  always_comb begin
    snap_sel_c = '0;
    for (int unsigned i = 0; i < CHUNKS; i++) begin
      if (addr_idx_c == i) begin
        snap_sel_c = snap_pad_c[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Access FSM with registered completion, read data and load pulse.
  always_ff @(posedge clk) begin
    if (res) begin
      state    <= IDLE;
      snapshot <= '0;
      staging  <= '0;
      rd_data  <= '0;
      complete <= 1'b0;
      load_en  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      complete <= 1'b0;
      load_en  <= 1'b0;
      rd_data  <= '0;
      unique case (state)
        IDLE: begin
          if (rf.rf_write_en) begin
            if (addr_ok_c) begin
              staging <= stage_wr_c[CNT_WIDTH-1:0];
            end
            if (addr_zero_c) begin
              load_en  <= 1'b1;
              wait_cnt <= '0;
              state    <= LOAD_WAIT;
            end else begin
              complete <= 1'b1;
              state    <= RESP;
            end
          end else if (rf.rf_read_en) begin
            complete <= 1'b1;
            state    <= RESP;
            if (addr_zero_c) begin
              snapshot <= cnt_value;
              rd_data  <= live_pad_c[BUS_WIDTH-1:0];
            end else begin
              rd_data  <= snap_sel_c;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        LOAD_WAIT: begin
          if (wait_cnt == WCW'(LOAD_WAIT_CYCLES)) begin
            complete <= 1'b1;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rf.rf_read_data       = rd_data;
  assign rf.rf_access_complete = complete;
  assign cnt_load              = staging;
  assign cnt_load_enable       = load_en;

endmodule

// File: tb/tb_counter_rf_bridge.sv
// Bench for counter_rf_bridge with a counter48 partner: table vectors, corner sequences, random accesses.
module tb_counter_rf_bridge;

  logic        clk;
  logic        res;
  logic [47:0] cnt_value;
  logic [47:0] cnt_load;
  logic        cnt_load_enable;

  counter_rf_bridge_if #(.AW(2), .BUS_WIDTH(16)) bus ();

  counter_rf_bridge #(.CNT_WIDTH(48), .BUS_WIDTH(16)) dut (
    .clk             (clk),
    .res             (res),
    .rf              (bus),
    .cnt_value       (cnt_value),
    .cnt_load        (cnt_load),
    .cnt_load_enable (cnt_load_enable)
  );

  counter48 #(.DATASIZE(48), .LOADABLE(1'b1)) u_cnt (
    .clk         (clk),
    .res         (res),
    .increment   (1'b1),
    .load        (cnt_load),
    .load_enable (cnt_load_enable),
    .value       (cnt_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              errors = 0;
  int              checks = 0;
  longint unsigned cyc = 0;
  int              pulse_cnt = 0;
  logic [47:0]     pulse_val = '0;

  // Reference model: staged chunks, snapshot, and the counter as base value plus elapsed edges.
  logic [15:0]     m_stage [3];
  logic [47:0]     m_snap;
  logic [47:0]     base_val;
  longint unsigned base_edge;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_load_enable) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_val <= cnt_load;
    end
  end

  function automatic logic [47:0] live_at(input longint unsigned e);
    return base_val + 48'(e - 1 - base_edge);
  endfunction

  function automatic logic [47:0] stage_word();
    return {m_stage[2], m_stage[1], m_stage[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    res = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    base_val  = '0;
    base_edge = cyc;
    m_snap    = '0;
    for (int i = 0; i < 3; i++) m_stage[i] = '0;
    res = 1'b0;
  endtask

  // One access; expectations come from the table when use_tbl is set, else from the model.
  task automatic access(input bit rd, input bit wr, input logic [1:0] addr, input logic [15:0] wd,
                        input bit use_tbl, input int t_lat, input int t_p, input logic [15:0] t_d,
                        input bit t_live, input string tag);
    longint unsigned e;
    int              m_lat, m_p, lat, p0, e_lat, e_p;
    logic [15:0]     m_d, e_d, got_d;
    p0 = pulse_cnt;
    bus.rf_read_en    = rd;
    bus.rf_write_en   = wr;
    bus.rf_address    = addr;
    bus.rf_write_data = wd;
    @(posedge clk);
    #1;
    e = cyc;
    bus.rf_read_en  = 1'b0;
    bus.rf_write_en = 1'b0;
    m_lat = 1;
    m_p   = 0;
    m_d   = '0;
    if (wr) begin
      if (addr != 2'd3) m_stage[addr] = wd;
      if (addr == 2'd0) begin
        m_lat     = 4;
        m_p       = 1;
        base_val  = stage_word();
        base_edge = e + 2;
      end
    end else if (rd) begin
      if (addr == 2'd0) begin
        m_snap = live_at(e);
        m_d    = m_snap[15:0];
      end else if (addr != 2'd3) begin
        m_d = m_snap[int'(addr)*16 +: 16];
      end
    end
    e_lat = use_tbl ? t_lat : m_lat;
    e_p   = use_tbl ? t_p : m_p;
    e_d   = (use_tbl && !t_live) ? t_d : m_d;
    lat   = 0;
    got_d = '0;
    for (int j = 0; j < 8; j++) begin
      if (bus.rf_access_complete) begin
        lat   = j + 1;
        got_d = bus.rf_read_data;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, " latency"}, 64'(lat), 64'(e_lat));
    check({tag, " rdata"}, 64'(got_d), 64'(e_d));
    @(posedge clk);
    #1;
    check({tag, " complete_drop"}, 64'(bus.rf_access_complete), 64'd0);
    check({tag, " rdata_zero"}, 64'(bus.rf_read_data), 64'd0);
    check({tag, " pulses"}, 64'(pulse_cnt - p0), 64'(e_p));
    if (e_p == 1) check({tag, " pulse_val"}, 64'(pulse_val), 64'(stage_word()));
    check({tag, " cnt_load"}, 64'(cnt_load), 64'(stage_word()));
  endtask

  typedef struct {
    int          gap;
    bit          rd;
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] wd;
    int          lat;
    int          pulses;
    logic [15:0] d;
    bit          live;
  } vec_t;

  vec_t vt [21];

  initial begin
    longint unsigned e;
    int              p0, n_comp, first, n_bad;
    bit              rd, wr;
    logic [1:0]      ad;
    logic [15:0]     wd;

    // gap, rd, wr, addr, wdata, latency, pulses, rdata, rdata-from-live-counter
    vt[0]  = '{0, 1'b1, 1'b0, 2'd0, 16'h0000, 1, 0, 16'h0000, 1'b1};
    vt[1]  = '{0, 1'b1, 1'b0, 2'd1, 16'h0000, 1, 0, 16'h0000, 1'b0};
    vt[2]  = '{0, 1'b1, 1'b0, 2'd2, 16'h0000, 1, 0, 16'h0000, 1'b0};
    vt[3]  = '{0, 1'b0, 1'b1, 2'd2, 16'h1234, 1, 0, 16'h0000, 1'b0};
    vt[4]  = '{0, 1'b0, 1'b1, 2'd1, 16'h5678, 1, 0, 16'h0000, 1'b0};
    vt[5]  = '{0, 1'b0, 1'b1, 2'd0, 16'h9ABC, 4, 1, 16'h0000, 1'b0};
    vt[6]  = '{0, 1'b1, 1'b0, 2'd0, 16'h0000, 1, 0, 16'h9ABE, 1'b0};
    vt[7]  = '{0, 1'b1, 1'b0, 2'd3, 16'h0000, 1, 0, 16'h0000, 1'b0};
    vt[8]  = '{0, 1'b0, 1'b1, 2'd3, 16'hFFFF, 1, 0, 16'h0000, 1'b0};
    vt[9]  = '{0, 1'b0, 1'b1, 2'd2, 16'h0000, 1, 0, 16'h0000, 1'b0};
    vt[10] = '{0, 1'b0, 1'b1, 2'd1, 16'hFFFF, 1, 0, 16'h0000, 1'b0};
    vt[11] = '{0, 1'b0, 1'b1, 2'd0, 16'hFFFE, 4, 1, 16'h0000, 1'b0};
    vt[12] = '{0, 1'b1, 1'b0, 2'd0, 16'h0000, 1, 0, 16'h0000, 1'b0};
    vt[13] = '{10, 1'b1, 1'b0, 2'd1, 16'h0000, 1, 0, 16'h0000, 1'b0};
    vt[14] = '{0, 1'b1, 1'b0, 2'd2, 16'h0000, 1, 0, 16'h0001, 1'b0};
    vt[15] = '{0, 1'b0, 1'b1, 2'd1, 16'hFFFF, 1, 0, 16'h0000, 1'b0};
    vt[16] = '{0, 1'b0, 1'b1, 2'd0, 16'hFFF0, 4, 1, 16'h0000, 1'b0};
    vt[17] = '{0, 1'b1, 1'b0, 2'd0, 16'h0000, 1, 0, 16'hFFF2, 1'b0};
    vt[18] = '{30, 1'b1, 1'b0, 2'd1, 16'h0000, 1, 0, 16'hFFFF, 1'b0};
    vt[19] = '{5, 1'b1, 1'b0, 2'd2, 16'h0000, 1, 0, 16'h0000, 1'b0};
    vt[20] = '{0, 1'b1, 1'b1, 2'd1, 16'hBEEF, 1, 0, 16'h0000, 1'b0};

    bus.rf_read_en    = 1'b0;
    bus.rf_write_en   = 1'b0;
    bus.rf_address    = '0;
    bus.rf_write_data = '0;
    res = 1'b1;
    @(posedge clk);
    #1;
    check("reset rdata", 64'(bus.rf_read_data), 64'd0);
    check("reset complete", 64'(bus.rf_access_complete), 64'd0);
    check("reset cnt_load", 64'(cnt_load), 64'd0);
    check("reset load_enable", 64'(cnt_load_enable), 64'd0);
    do_reset(1);

    for (int i = 0; i < 21; i++) begin
      repeat (vt[i].gap) @(posedge clk);
      #1;
      access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, 1'b1, vt[i].lat, vt[i].pulses,
             vt[i].d, vt[i].live, $sformatf("vec%0d", i));
    end
    check("pair staging", 64'(cnt_load), 64'h0000_BEEF_FFF0);

    // Strobe during LOAD_WAIT must be ignored.
    p0 = pulse_cnt;
    bus.rf_write_en   = 1'b1;
    bus.rf_address    = 2'd0;
    bus.rf_write_data = 16'h0042;
    @(posedge clk);
    #1;
    e = cyc;
    bus.rf_write_en = 1'b0;
    m_stage[0] = 16'h0042;
    base_val   = stage_word();
    base_edge  = e + 2;
    @(posedge clk);
    #1;
    bus.rf_write_en   = 1'b1;
    bus.rf_address    = 2'd1;
    bus.rf_write_data = 16'hDEAD;
    @(posedge clk);
    #1;
    bus.rf_write_en = 1'b0;
    n_comp = 0;
    first  = 0;
    for (int j = 0; j < 6; j++) begin
      if (bus.rf_access_complete) begin
        n_comp++;
        if (first == 0) first = int'(cyc - e) + 1;
      end
      @(posedge clk);
      #1;
    end
    check("lw latency", 64'(first), 64'd4);
    check("lw completions", 64'(n_comp), 64'd1);
    check("lw pulses", 64'(pulse_cnt - p0), 64'd1);
    check("lw cnt_load", 64'(cnt_load), 64'h0000_BEEF_0042);

    // Reset right after a chunk-0 write aborts the access.
    bus.rf_write_en   = 1'b1;
    bus.rf_address    = 2'd0;
    bus.rf_write_data = 16'h7777;
    @(posedge clk);
    #1;
    bus.rf_write_en = 1'b0;
    do_reset(1);
    check("abort load_enable", 64'(cnt_load_enable), 64'd0);
    check("abort complete", 64'(bus.rf_access_complete), 64'd0);
    check("abort cnt_load", 64'(cnt_load), 64'd0);
    n_bad = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      if (bus.rf_access_complete || cnt_load_enable) n_bad++;
    end
    check("abort quiet", 64'(n_bad), 64'd0);
    access(1'b1, 1'b0, 2'd0, 16'h0, 1'b0, 0, 0, 16'h0, 1'b0, "abort read0");
    access(1'b1, 1'b0, 2'd2, 16'h0, 1'b0, 0, 0, 16'h0, 1'b0, "abort read2");

    // Random accesses against the model.
    for (int i = 0; i < 150; i++) begin
      rd = 1'(($urandom_range(0, 1)));
      wr = 1'(($urandom_range(0, 2) == 0));
      if (!rd && !wr) rd = 1'b1;
      ad = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      access(rd, wr, ad, wd, 1'b0, 0, 0, 16'h0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
